memory_stage: RTL and testbench
===============================

# memory_stage

Memory-access stage of the 16-bit pipelined CPU, directly downstream of the Execute stage. Consumes the Execute pipeline register outputs (ALU result/effective address, divider remainder, store data, divider stall) and performs at most one data-memory access per instruction over a request/acknowledge bus with variable latency. Holds the pipeline via `MemStall` while an access is outstanding. Registers the write-back result into the MEM/WB pipeline register.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles in REQ without `MemAck` before the access is abandoned.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `Stall`  in  1  global hold from downstream/hazard unit; freezes FSM launch and MEM/WB register.
- `Valid`  in  1  Execute register holds a real instruction (0 = bubble).
- `DivStall`  in  1  divider busy in Execute; instruction treated as bubble while high.
- `ALUOut`  in  16  ALU result / effective address.
- `Remainder`  in  16  divider remainder.
- `DataOut1Out`  in  16  store data.
- `MemRead`, `MemWrite`  in  1 each  load / store; never both high.
- `ResultSel`  in  1  non-load result: 0 = `ALUOut`, 1 = `Remainder`.
- `RegWrite`  in  1  instruction writes a register.
- `WbRegIn`  in  3  destination register number.
- `MemReq`  out  1  data-memory request.
- `MemWe`  out  1  request is a write.
- `MemAddr`, `MemWData`  out  16 each  request address / write data.
- `MemRData`  in  16  read data; valid when `MemAck`.
- `MemAck`  in  1  access complete.
- `MemStall`  out  1  hold Execute and earlier stages.
- `BusError`  out  1  sticky timeout flag.
- `FwdData`  out  16  combinational forwarding value (`Remainder` if `ResultSel`, else `ALUOut`) for Execute's forwarding muxes.
- `WbValid`, `WbRegWrite`  out  1 each  MEM/WB valid, write enable.
- `WbReg`  out  3  MEM/WB destination.
- `WbData`  out  16  MEM/WB result.

## Operation
- Live op = `Valid & ~DivStall`. Mem op = live op with `MemRead | MemWrite`.
- FSM states IDLE, REQ, DONE.
- IDLE, non-mem live op, `~Stall`: MEM/WB loads `FwdData`, `RegWrite`, `WbRegIn`, `WbValid=1`.
- IDLE, bubble, `~Stall`: MEM/WB loads `WbValid=0` and `WbRegWrite=0`.
- IDLE, mem op, `~Stall`: capture address, wdata and we into request registers; go REQ.
- IDLE, mem op, `Stall`: no launch.
- REQ: `MemReq=1`; wait counter increments each cycle.
  - On `MemAck`: capture `MemRData` for loads; go DONE.
  - If the counter reaches `TIMEOUT-1` without ack: set `BusError`, load data = 0; go DONE.
- DONE, `~Stall`: MEM/WB loads data (load: captured rdata; store: `WbRegWrite=0`); `WbValid=1`; go IDLE. With `Stall`, remain in DONE.
- `MemStall` = (IDLE & mem op) | REQ. It is deasserted in DONE so Execute advances in the same cycle the result retires.
- `MemAck` outside REQ is ignored. `MemRData` is sampled only on an ack in REQ.
- `BusError` stays set until `rst`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counter 0, request registers 0.
- Reset mid-access: `MemReq` low from the cycle after `rst` is sampled. A late `MemAck` is ignored.
- Non-mem op: `WbData` is valid 1 cycle after it is presented.
- Load with ack in the first REQ cycle:
  - cycle 0: IDLE, launch.
  - cycle 1: REQ, ack.
  - cycle 2: DONE, write MEM/WB.
  - `WbValid` visible in cycle 3.
- Each extra wait cycle adds 1 to load latency.
- `MemReq`, `MemAddr`, `MemWData` and `MemWe` come from registers and are stable for the whole of REQ.
- `Stall` high in REQ: the access completes normally; the FSM waits in DONE.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum `mem_state_t` (IDLE, REQ, DONE);
  - the `ResultSel` encodings;
  - the default `TIMEOUT`.
- Sub-module `mem_wb_reg` is the MEM/WB pipeline register. It has enable (`~Stall` & retire), synchronous reset and fields valid/regwrite/reg/data.
- FSM, counter and request registers live in the top module.

## Test plan
- Non-mem op, `ALUOut=16'h1234`, `RegWrite=1`, `WbRegIn=3` -> next cycle `WbValid=1`, `WbReg=3`, `WbData=16'h1234`; `MemStall` never high.
- `ResultSel=1`, `Remainder=16'h0007` -> `FwdData=16'h0007` same cycle; `WbData=16'h0007` next cycle.
- Load addr `16'h0040`, ack after 3 REQ cycles with `MemRData=16'hBEEF` -> `MemStall` high 4 cycles; `MemAddr=16'h0040` stable; `WbData=16'hBEEF`.
- Store addr `16'h0010`, data `16'h00FF`, immediate ack -> `MemWe=1`, `MemWData=16'h00FF`; `WbRegWrite=0`, `WbValid=1`.
- Load with no ack, `TIMEOUT=4` -> `BusError=1` after 4 REQ cycles; `WbData=0`; `BusError` held until `rst`.
- `rst` asserted during REQ, then a late `MemAck` -> `MemReq=0` next cycle; all outputs 0; ack ignored. Separately, `DivStall=1` with `MemRead=1` -> no request issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the memory-access stage and its sub-blocks.
//   mem_state_t      : memory-access FSM states (IDLE, REQ, DONE)
//   RES_ALU/RES_REM  : ResultSel encodings for the non-load result
//   DEFAULT_TIMEOUT  : cycles in REQ without an ack before the access is abandoned
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic RES_ALU = 1'b0;
  localparam logic RES_REM = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
//   clk, rst                  : clock, synchronous active-high reset
//   en                        : load enable (retiring instruction and no global stall)
//   d_valid/d_regwrite/d_reg/d_data : next values
//   valid/regwrite/wreg/data  : registered MEM/WB fields
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        d_valid,
  input  logic        d_regwrite,
  input  logic [2:0]  d_reg,
  input  logic [15:0] d_data,
  output logic        valid,
  output logic        regwrite,
  output logic [2:0]  wreg,
  output logic [15:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      regwrite <= 1'b0;
      wreg     <= 3'd0;
      data     <= 16'd0;
    end else if (en) begin
      valid    <= d_valid;
      regwrite <= d_regwrite;
      wreg     <= d_reg;
      data     <= d_data;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: memory-access stage of the 16-bit pipelined CPU.
//   Inputs from the Execute register: Valid, DivStall, ALUOut, Remainder,
//   DataOut1Out, MemRead, MemWrite, ResultSel, RegWrite, WbRegIn; global Stall.
//   Data-memory bus: MemReq/MemWe/MemAddr/MemWData out, MemRData/MemAck in.
//   MemStall holds upstream stages while an access is pending; BusError is a
//   sticky timeout flag; FwdData is the combinational forwarding value;
//   WbValid/WbRegWrite/WbReg/WbData are the MEM/WB register outputs.
module memory_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Valid,
  input  logic        DivStall,
  input  logic [15:0] ALUOut,
  input  logic [15:0] Remainder,
  input  logic [15:0] DataOut1Out,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ResultSel,
  input  logic        RegWrite,
  input  logic [2:0]  WbRegIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  input  logic [15:0] MemRData,
  input  logic        MemAck,
  output logic        MemStall,
  output logic        BusError,
  output logic [15:0] FwdData,
  output logic        WbValid,
  output logic        WbRegWrite,
  output logic [2:0]  WbReg,
  output logic [15:0] WbData
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          req_reg;
  logic          we_reg;
  logic [15:0]   addr_reg;
  logic [15:0]   wdata_reg;
  logic [15:0]   rdata_reg;
  logic [2:0]    wreg_reg;
  logic          regwrite_reg;
  logic          buserr_reg;

  logic        live;
  logic        memop;
  logic        wb_en;
  logic        wb_valid_next;
  logic        wb_regwrite_next;
  logic [2:0]  wb_reg_next;
  logic [15:0] wb_data_next;

  assign live  = Valid & ~DivStall;
  assign memop = live & (MemRead | MemWrite);

  assign FwdData  = (ResultSel == RES_REM) ? Remainder : ALUOut;
  // Released in DONE so Execute advances in the cycle the access retires.
  assign MemStall = ((state_reg == IDLE) & memop) | (state_reg == REQ);

  assign MemReq   = req_reg;
  assign MemWe    = we_reg;
  assign MemAddr  = addr_reg;
  assign MemWData = wdata_reg;
  assign BusError = buserr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= 16'd0;
      wdata_reg    <= 16'd0;
      rdata_reg    <= 16'd0;
      wreg_reg     <= 3'd0;
      regwrite_reg <= 1'b0;
      buserr_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (memop && !Stall) begin
            addr_reg     <= ALUOut;
            wdata_reg    <= DataOut1Out;
            we_reg       <= MemWrite;
            req_reg      <= 1'b1;
            cnt_reg      <= '0;
            wreg_reg     <= WbRegIn;
            regwrite_reg <= RegWrite;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (MemAck) begin
            rdata_reg <= we_reg ? 16'd0 : MemRData;
            req_reg   <= 1'b0;
            state_reg <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            buserr_reg <= 1'b1;
            rdata_reg  <= 16'd0;
            req_reg    <= 1'b0;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (!Stall) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB only advances when an instruction retires: a non-memory op or
  // bubble straight from IDLE, or a finished access from DONE.
  always_comb begin
    wb_en            = 1'b0;
    wb_valid_next    = 1'b0;
    wb_regwrite_next = 1'b0;
    wb_reg_next      = WbRegIn;
    wb_data_next     = FwdData;
    case (state_reg)
      IDLE: begin
        if (!memop) begin
          wb_en            = ~Stall;
          wb_valid_next    = live;
          wb_regwrite_next = live & RegWrite;
        end
      end
      DONE: begin
        wb_en            = ~Stall;
        wb_valid_next    = 1'b1;
        wb_regwrite_next = ~we_reg & regwrite_reg;
        wb_reg_next      = wreg_reg;
        wb_data_next     = rdata_reg;
      end
      default: begin
        wb_en = 1'b0;
      end
    endcase
  end

  mem_wb_reg u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .en         (wb_en),
    .d_valid    (wb_valid_next),
    .d_regwrite (wb_regwrite_next),
    .d_reg      (wb_reg_next),
    .d_data     (wb_data_next),
    .valid      (WbValid),
    .regwrite   (WbRegWrite),
    .wreg       (WbReg),
    .data       (WbData)
  );

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, Stall, Valid, DivStall, MemRead, MemWrite, ResultSel, RegWrite, MemAck;
  logic [15:0] ALUOut, Remainder, DataOut1Out, MemRData;
  logic [2:0]  WbRegIn;
  logic        MemReq, MemWe, MemStall, BusError, WbValid, WbRegWrite;
  logic [15:0] MemAddr, MemWData, FwdData, WbData;
  logic [2:0]  WbReg;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_buserr = 1'b0;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Valid(Valid), .DivStall(DivStall),
    .ALUOut(ALUOut), .Remainder(Remainder), .DataOut1Out(DataOut1Out),
    .MemRead(MemRead), .MemWrite(MemWrite), .ResultSel(ResultSel),
    .RegWrite(RegWrite), .WbRegIn(WbRegIn), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
    .MemStall(MemStall), .BusError(BusError), .FwdData(FwdData),
    .WbValid(WbValid), .WbRegWrite(WbRegWrite), .WbReg(WbReg), .WbData(WbData)
  );

  task automatic idle_inputs();
    Stall = 0; Valid = 0; DivStall = 0; MemRead = 0; MemWrite = 0; ResultSel = 0;
    RegWrite = 0; WbRegIn = 0; ALUOut = 0; Remainder = 0; DataOut1Out = 0;
    MemAck = 0; MemRData = 0;
  endtask

  // Presents one instruction, plays the memory side (ack in REQ cycle ack_at,
  // 0 = never), holds it while MemStall is high, then checks the retired result.
  task automatic run_op(input string tag, input logic v, div, rd, wr, sel, rw,
                        input logic [2:0] r, input logic [15:0] alu, rem, sdata, rdata,
                        input int ack_at);
    int stalls, reqs, exp_stalls, exp_reqs;
    logic live, mem, first, exp_valid, exp_rw;
    logic [15:0] fwd, exp_data;
    live = v && !div;
    mem  = live && (rd || wr);
    fwd  = sel ? rem : alu;
    if (!mem) begin
      exp_stalls = 0; exp_reqs = 0; exp_valid = live; exp_rw = live && rw; exp_data = fwd;
    end else if (ack_at > 0 && ack_at <= TO) begin
      exp_stalls = 1 + ack_at; exp_reqs = ack_at; exp_valid = 1'b1;
      exp_rw = rd && rw; exp_data = rdata;
    end else begin
      exp_stalls = 1 + TO; exp_reqs = TO; exp_valid = 1'b1;
      exp_rw = rd && rw; exp_data = 16'h0000; exp_buserr = 1'b1;
    end
    @(posedge clk); #1;
    Valid = v; DivStall = div; MemRead = rd; MemWrite = wr; ResultSel = sel;
    RegWrite = rw; WbRegIn = r; ALUOut = alu; Remainder = rem; DataOut1Out = sdata;
    stalls = 0; reqs = 0; first = 1'b1;
    forever begin
      @(negedge clk);
      MemAck = 1'b0;
      if (first) begin
        vectors++;
        if (FwdData !== fwd) begin
          miscompares++;
          $display("FAIL %s fwd: got %h expected %h", tag, FwdData, fwd);
        end
        first = 1'b0;
      end
      if (MemReq === 1'b1) begin
        reqs++;
        vectors++;
        if ({MemAddr, MemWe, MemWData} !== {alu, wr, sdata}) begin
          miscompares++;
          $display("FAIL %s req_fields: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   tag, MemAddr, MemWe, MemWData, alu, wr, sdata);
        end
        if (reqs == ack_at) begin
          MemAck = 1'b1; MemRData = rdata;
        end else begin
          MemRData = 16'($urandom);
        end
      end
      if (MemStall !== 1'b1) break;
      stalls++;
      if (stalls > TO + 10) begin
        miscompares++;
        $display("FAIL %s stall_bound: MemStall still high after %0d cycles", tag, stalls);
        break;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (stalls != exp_stalls) begin
      miscompares++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stalls, exp_stalls);
    end
    vectors++;
    if (reqs != exp_reqs) begin
      miscompares++;
      $display("FAIL %s req_cycles: got %0d expected %0d", tag, reqs, exp_reqs);
    end
    @(posedge clk); #1;
    MemAck = 0; Valid = 0; MemRead = 0; MemWrite = 0; DivStall = 0;
    @(negedge clk);
    vectors++;
    if ({WbValid, WbRegWrite, BusError, MemReq} !== {exp_valid, exp_rw, exp_buserr, 1'b0}) begin
      miscompares++;
      $display("FAIL %s wb_flags: got valid=%b rw=%b buserr=%b req=%b expected %b %b %b 0",
               tag, WbValid, WbRegWrite, BusError, MemReq, exp_valid, exp_rw, exp_buserr);
    end
    if (exp_valid) begin
      vectors++;
      if (WbReg !== r) begin
        miscompares++;
        $display("FAIL %s wb_reg: got %0d expected %0d", tag, WbReg, r);
      end
      if (!(mem && wr)) begin
        vectors++;
        if (WbData !== exp_data) begin
          miscompares++;
          $display("FAIL %s wb_data: got %h expected %h", tag, WbData, exp_data);
        end
      end
    end
    $display("op %s: stalls=%0d reqs=%0d WbValid=%b WbData=%h", tag, stalls, reqs, WbValid, WbData);
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({MemReq, MemWe, MemAddr, MemWData, MemStall, BusError, FwdData,
         WbValid, WbRegWrite, WbReg, WbData} !== '0) begin
      miscompares++;
      $display("FAIL %s all_zero: got req=%b we=%b addr=%h wdata=%h stall=%b err=%b fwd=%h wbv=%b wbrw=%b wbreg=%0d wbdata=%h expected all 0",
               tag, MemReq, MemWe, MemAddr, MemWData, MemStall, BusError, FwdData,
               WbValid, WbRegWrite, WbReg, WbData);
    end
    $display("check %s: outputs after reset", tag);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
  endtask

  task automatic test_nonmem();
    run_op("nonmem", 1, 0, 0, 0, 0, 1, 3'd3, 16'h1234, 16'h9999, 16'h0000, 16'h0000, 1);
    run_op("remainder", 1, 0, 0, 0, 1, 1, 3'd5, 16'hAAAA, 16'h0007, 16'h0000, 16'h0000, 1);
  endtask

  task automatic test_load();
    run_op("load", 1, 0, 1, 0, 0, 1, 3'd2, 16'h0040, 16'h0000, 16'h0000, 16'hBEEF, 3);
    run_op("load_fast", 1, 0, 1, 0, 0, 1, 3'd4, 16'h0042, 16'h0000, 16'h0000, 16'h1357, 1);
  endtask

  task automatic test_store();
    run_op("store", 1, 0, 0, 1, 0, 0, 3'd1, 16'h0010, 16'h0000, 16'h00FF, 16'h0000, 1);
  endtask

  task automatic test_divstall();
    run_op("divstall", 1, 1, 1, 0, 0, 1, 3'd6, 16'h0020, 16'h0000, 16'h0000, 16'h1111, 1);
  endtask

  task automatic test_stall();
    // Mem op under Stall in IDLE must not launch.
    @(posedge clk); #1;
    Valid = 1; MemRead = 1; RegWrite = 1; WbRegIn = 3'd7; ALUOut = 16'h0080; Stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({MemReq, MemStall} !== 2'b01) begin
        miscompares++;
        $display("FAIL stall_idle: got req=%b memstall=%b expected req=0 memstall=1", MemReq, MemStall);
      end
    end
    @(posedge clk); #1 Stall = 0;
    @(posedge clk); #1 Stall = 1; MemAck = 1; MemRData = 16'h5A5A;
    @(negedge clk);
    vectors++;
    if (MemReq !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_req: got MemReq=%b expected 1", MemReq);
    end
    @(posedge clk); #1 MemAck = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({MemReq, MemStall} !== 2'b00 || WbData === 16'h5A5A) begin
        miscompares++;
        $display("FAIL stall_done: got req=%b memstall=%b wbdata=%h expected req=0 memstall=0 wbdata not yet 5a5a",
                 MemReq, MemStall, WbData);
      end
      @(posedge clk); #1;
    end
    Stall = 0;
    @(posedge clk); #1 Valid = 0; MemRead = 0;
    @(negedge clk);
    vectors++;
    if ({WbValid, WbRegWrite, WbReg, WbData} !== {1'b1, 1'b1, 3'd7, 16'h5A5A}) begin
      miscompares++;
      $display("FAIL stall_retire: got v=%b rw=%b reg=%0d data=%h expected 1 1 7 5a5a",
               WbValid, WbRegWrite, WbReg, WbData);
    end
    $display("op stall_hold: WbData=%h", WbData);
  endtask

  task automatic test_timeout();
    run_op("timeout", 1, 0, 1, 0, 0, 1, 3'd2, 16'h0050, 16'h0000, 16'h0000, 16'hDEAD, 0);
    run_op("after_timeout", 1, 0, 0, 0, 0, 1, 3'd1, 16'h0101, 16'h0000, 16'h0000, 16'h0000, 1);
  endtask

  task automatic test_reset_mid();
    int guard;
    @(posedge clk); #1;
    Valid = 1; MemRead = 1; RegWrite = 1; WbRegIn = 3'd4; ALUOut = 16'h0100;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (MemReq !== 1'b1 && guard < 10);
    vectors++;
    if (MemReq !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_launch: got MemReq=%b expected 1", MemReq);
    end
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("reset_mid");
    exp_buserr = 1'b0;
    @(posedge clk); #1 rst = 1'b0; MemAck = 1; MemRData = 16'hFFFF;
    @(negedge clk);
    vectors++;
    if (MemReq !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack_req: got MemReq=%b expected 0", MemReq);
    end
    @(posedge clk); #1 MemAck = 0;
    @(negedge clk);
    check_all_zero("late_ack");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int k, ack;
      logic [2:0] r;
      logic [15:0] a, m, d, rd;
      k = $urandom_range(0, 5);
      r = 3'($urandom); a = 16'($urandom); m = 16'($urandom);
      d = 16'($urandom); rd = 16'($urandom);
      ack = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      case (k)
        0: run_op("rnd_bubble", 0, 0, 1'($urandom), 0, 1'($urandom), 1, r, a, m, d, rd, ack);
        1: run_op("rnd_div", 1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1, r, a, m, d, rd, ack);
        2, 3: run_op("rnd_alu", 1, 0, 0, 0, 1'($urandom), 1'($urandom), r, a, m, d, rd, ack);
        4: run_op("rnd_load", 1, 0, 1, 0, 1'($urandom), 1'($urandom), r, a, m, d, rd, ack);
        default: run_op("rnd_store", 1, 0, 0, 1, 1'($urandom), 1'($urandom), r, a, m, d, rd, ack);
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_divstall();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
